// File: rtl/mult_div_seq_if.sv
// ============================================================================
// Module : mult_div_seq_if
// Brief  : Request/result bundle between the CPU control unit and the
//          iterative multiply/divide engine. MULT_DIV_UNSIGNED_EN adds op_unsigned.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mult_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef MULT_DIV_UNSIGNED_EN
  logic             op_unsigned;
`endif
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
`ifdef MULT_DIV_UNSIGNED_EN
    output op_unsigned,
`endif
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b,
`ifdef MULT_DIV_UNSIGNED_EN
    input  op_unsigned,
`endif
    output busy, done, div0, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_seq.sv
// ============================================================================
// Module : mult_div_seq
// Brief  : Radix-2 signed multiply / restoring signed divide owning HI/LO,
//          one bit per clock. Define MULT_DIV_UNSIGNED_EN to add multu/divu.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  mult_div_seq_if.slave  bus
);

  localparam int         CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH:0]     mag_a;
  logic [WIDTH:0]     mag_b;
  logic               op_div;
  logic               sign_a;
  logic               sign_b;
  logic               done_r;
  logic               div0_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               is_unsigned;
`ifdef MULT_DIV_UNSIGNED_EN
  assign is_unsigned = bus.op_unsigned;
`else
  assign is_unsigned = 1'b0;
`endif

  // Operands are widened by one bit so |0x80..0| is representable.
  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;
  logic [WIDTH:0] abs_a;
  logic [WIDTH:0] abs_b;

  assign ext_a = {bus.a[WIDTH-1] & ~is_unsigned, bus.a};
  assign ext_b = {bus.b[WIDTH-1] & ~is_unsigned, bus.b};
  assign abs_a = ext_a[WIDTH] ? -ext_a : ext_a;
  assign abs_b = ext_b[WIDTH] ? -ext_b : ext_b;

  // Multiply: acc = {carry/high, low multiplier bits}, shifted right.
  // Divide:   acc = {remainder, quotient}, shifted left.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   new_rem;
  logic             fits;
  logic [2*WIDTH:0] next_acc;

  always_comb begin
    mul_sum  = acc[0] ? (acc[2*WIDTH:WIDTH] + mag_a) : acc[2*WIDTH:WIDTH];
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial    = shifted - mag_b;
    fits     = (shifted >= mag_b);
    new_rem  = fits ? trial : shifted;
    next_acc = op_div ? {new_rem, acc[WIDTH-2:0], fits}
                      : {1'b0, mul_sum, acc[WIDTH-1:1]};
  end

  logic               negate;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    negate   = sign_a ^ sign_b;
    prod     = acc[2*WIDTH-1:0];
    prod_fix = negate ? -prod : prod;
    quo_fix  = negate ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // Remainder follows the dividend sign (truncation toward zero).
    rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (op_div) begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      op_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      done_r <= 1'b0;
      div0_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      div0_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.op && (bus.b == '0)) begin
              div0_r <= 1'b1;
            end else begin
              op_div <= bus.op;
              sign_a <= ext_a[WIDTH];
              sign_b <= ext_b[WIDTH];
              mag_a  <= abs_a;
              mag_b  <= abs_b;
              acc    <= bus.op ? {{(WIDTH+1){1'b0}}, abs_a[WIDTH-1:0]}
                               : {{(WIDTH+1){1'b0}}, abs_b[WIDTH-1:0]};
              count  <= '0;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          acc   <= next_acc;
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi_r   <= fix_hi;
          lo_r   <= fix_lo;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.div0 = div0_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

`default_nettype wire
